// File: rtl/cae_mc_ldsum.sv
// cae_mc_ldsum: streaming 8-byte load-and-sum engine for one memory-controller port.
// Issues i_count sequential loads from i_base, sums the returned data mod 2^64 and
// pulses o_done with the final sum. Define CAE_LDSUM_PERF_EN to add the o_cycles
// busy-cycle counter port.

module cae_mc_ldsum #(
  parameter int unsigned MAX_OUT = 16
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [47:0] i_base,
  input  logic [31:0] i_count,
  output logic        o_busy,
  output logic        o_done,
  output logic [63:0] o_sum,
  output logic        o_err,
  output logic        mc_req_ld,
  output logic        mc_req_st,
  output logic [1:0]  mc_req_size,
  output logic [47:0] mc_req_vadr,
  output logic [63:0] mc_req_wrd_rdctl,
  output logic        mc_req_flush,
  output logic        mc_rsp_stall,
  input  logic        mc_rd_rq_stall,
  input  logic        mc_rsp_push,
  input  logic [63:0] mc_rsp_data,
  input  logic [31:0] mc_rsp_rdctl
`ifdef CAE_LDSUM_PERF_EN
  ,
  output logic [31:0] o_cycles
`endif
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e      r_state;
  logic [47:0] r_base;
  logic [31:0] r_count;
  logic [31:0] r_issued;
  logic [31:0] r_received;
  logic [63:0] r_sum;
  logic        r_err;
  logic        r_busy;
  logic        r_done;
  logic        r_req_ld;
  logic [47:0] r_req_vadr;
  logic [31:0] r_req_idx;

  logic        w_active;
  logic        w_rsp;
  logic        w_issue;
  logic [31:0] w_outstanding;
  logic [31:0] w_issued_nx;
  logic [31:0] w_received_nx;
  logic [47:0] w_base_aligned;

  // Issue/response qualifiers; credit uses registered counters only, so a
  // response in the same cycle does not free a slot until the next cycle.
  always_comb begin
    w_active       = (r_state == StIssue) || (r_state == StDrain);
    w_rsp          = w_active && mc_rsp_push;
    w_outstanding  = r_issued - r_received;
    w_issue        = (r_state == StIssue) && (r_issued < r_count) &&
                     (w_outstanding < MAX_OUT) && !mc_rd_rq_stall;
    w_issued_nx    = r_issued + {31'd0, w_issue};
    w_received_nx  = r_received + {31'd0, w_rsp};
    w_base_aligned = i_base & ~48'h7;
  end

  // Control FSM, counters, accumulator and registered MC request outputs.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_base     <= '0;
      r_count    <= '0;
      r_issued   <= '0;
      r_received <= '0;
      r_sum      <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_req_ld   <= 1'b0;
      r_req_vadr <= '0;
      r_req_idx  <= '0;
    end else begin
      r_req_ld   <= 1'b0;
      r_done     <= 1'b0;
      r_received <= w_received_nx;

      if (w_rsp) begin
        r_sum <= r_sum + mc_rsp_data;
        if (mc_rsp_rdctl >= r_count) begin
          r_err <= 1'b1;
        end
      end

      // A start that arrives while a run is in progress is dropped but flagged.
      if (i_start && (r_state != StIdle)) begin
        r_err <= 1'b1;
      end

      if (w_issue) begin
        r_req_ld   <= 1'b1;
        r_req_vadr <= r_base + {13'd0, r_issued, 3'b000};
        r_req_idx  <= r_issued;
        r_issued   <= w_issued_nx;
      end

      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_base     <= w_base_aligned;
            r_count    <= i_count;
            r_issued   <= '0;
            r_received <= '0;
            r_sum      <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= (i_count == 32'd0) ? StDone : StIssue;
          end
        end
        StIssue: begin
          if (w_issued_nx == r_count) begin
            r_state <= StDrain;
          end
        end
        StDrain: begin
          // Look at the next-cycle count so o_done lands two cycles after the last push.
          if (w_received_nx == r_count) begin
            r_state <= StDone;
          end
        end
        StDone: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef CAE_LDSUM_PERF_EN
  logic [31:0] r_cycles;

  // Saturating count of busy cycles, cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_cycles <= '0;
    end else if ((r_state == StIdle) && i_start) begin
      r_cycles <= '0;
    end else if (r_busy && (r_cycles != 32'hFFFF_FFFF)) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign o_cycles = r_cycles;
`endif

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_sum            = r_sum;
  assign o_err            = r_err;
  assign mc_req_ld        = r_req_ld;
  assign mc_req_st        = 1'b0;
  assign mc_req_size      = 2'd3;
  assign mc_req_vadr      = r_req_vadr;
  assign mc_req_wrd_rdctl = {32'd0, r_req_idx};
  assign mc_req_flush     = 1'b0;
  assign mc_rsp_stall     = 1'b0;

endmodule

// File: tb/tb_cae_mc_ldsum.sv
// Scoreboard bench for cae_mc_ldsum: stimulus pushes expected requests and results,
// a negedge monitor pops and compares whenever the DUT presents them.

module tb_cae_mc_ldsum;

  localparam int unsigned MAX_OUT = 2;

  logic        clk;
  logic        i_reset;
  logic        i_start;
  logic [47:0] i_base;
  logic [31:0] i_count;
  logic        o_busy;
  logic        o_done;
  logic [63:0] o_sum;
  logic        o_err;
  logic        mc_req_ld;
  logic        mc_req_st;
  logic [1:0]  mc_req_size;
  logic [47:0] mc_req_vadr;
  logic [63:0] mc_req_wrd_rdctl;
  logic        mc_req_flush;
  logic        mc_rsp_stall;
  logic        mc_rd_rq_stall;
  logic        mc_rsp_push;
  logic [63:0] mc_rsp_data;
  logic [31:0] mc_rsp_rdctl;
`ifdef CAE_LDSUM_PERF_EN
  logic [31:0] o_cycles;
`endif

  cae_mc_ldsum #(.MAX_OUT(MAX_OUT)) dut (
    .clk              (clk),
    .i_reset          (i_reset),
    .i_start          (i_start),
    .i_base           (i_base),
    .i_count          (i_count),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_sum            (o_sum),
    .o_err            (o_err),
    .mc_req_ld        (mc_req_ld),
    .mc_req_st        (mc_req_st),
    .mc_req_size      (mc_req_size),
    .mc_req_vadr      (mc_req_vadr),
    .mc_req_wrd_rdctl (mc_req_wrd_rdctl),
    .mc_req_flush     (mc_req_flush),
    .mc_rsp_stall     (mc_rsp_stall),
    .mc_rd_rq_stall   (mc_rd_rq_stall),
    .mc_rsp_push      (mc_rsp_push),
    .mc_rsp_data      (mc_rsp_data),
    .mc_rsp_rdctl     (mc_rsp_rdctl)
`ifdef CAE_LDSUM_PERF_EN
    ,
    .o_cycles         (o_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Scoreboard queues
  logic [47:0] exp_vadr_q[$];
  logic [31:0] exp_idx_q[$];
  logic [63:0] exp_sum_q[$];
  logic        exp_err_q[$];

  // Auto responder state
  logic [63:0] mem[8];
  int          pend_idx_q[$];
  int          pend_due_q[$];
  bit          auto_en    = 1'b0;
  int          lat        = 1;
  int          hold_until = 0;

  // Per-run bookkeeping
  int run_reqs      = 0;
  int run_push      = 0;
  int first_req_cyc = -1;
  int last_push_cyc = 0;
  int done_cnt      = 0;
  int done_cyc      = 0;
  int start_cyc     = 0;
  int busy_cnt      = 0;
  bit prev_stall    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  // Monitor: compares DUT outputs against the scoreboard queues.
  always @(negedge clk) begin
    if (i_reset) begin
      run_reqs   = 0;
      run_push   = 0;
      prev_stall = 1'b0;
      pend_idx_q.delete();
      pend_due_q.delete();
    end else begin
      if (mc_req_ld) begin
        run_reqs++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
        check("outstanding_le_max", 64'((run_reqs - run_push) <= int'(MAX_OUT)), 64'd1);
        check("no_req_after_stall", 64'(prev_stall), 64'd0);
        if (exp_vadr_q.size() == 0) begin
          fail_now("unexpected_req");
        end else begin
          check("req_vadr", 64'(mc_req_vadr), 64'(exp_vadr_q.pop_front()));
          check("req_rdctl", mc_req_wrd_rdctl, {32'd0, exp_idx_q.pop_front()});
        end
        if (auto_en) begin
          pend_idx_q.push_back(int'(mc_req_wrd_rdctl[31:0]));
          pend_due_q.push_back(cyc + lat);
        end
      end
      if (mc_rsp_push) begin
        run_push++;
        last_push_cyc = cyc;
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_low_at_done", 64'(o_busy), 64'd0);
        if (exp_sum_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          check("done_sum", o_sum, exp_sum_q.pop_front());
          check("done_err", 64'(o_err), 64'(exp_err_q.pop_front()));
        end
      end
      if (o_busy) busy_cnt++;
      prev_stall = mc_rd_rq_stall;
    end
  end

  // Advance one cycle; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    mc_rsp_push = 1'b0;
    if (auto_en && (pend_idx_q.size() > 0) && (cyc >= hold_until) &&
        (pend_due_q[0] <= cyc)) begin
      int idx;
      idx = pend_idx_q.pop_front();
      void'(pend_due_q.pop_front());
      mc_rsp_push  = 1'b1;
      mc_rsp_rdctl = 32'(idx);
      mc_rsp_data  = mem[idx % 8];
    end
  endtask

  task automatic drive_rsp(input logic [31:0] rd, input logic [63:0] d);
    mc_rsp_push  = 1'b1;
    mc_rsp_rdctl = rd;
    mc_rsp_data  = d;
  endtask

  task automatic expect_reqs(input logic [47:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_vadr_q.push_back(base + 48'(8 * i));
      exp_idx_q.push_back(32'(i));
    end
  endtask

  task automatic expect_done(input logic [63:0] s, input logic e);
    exp_sum_q.push_back(s);
    exp_err_q.push_back(e);
  endtask

  task automatic start_run(input logic [47:0] base, input logic [31:0] cnt);
    tick();
    i_start       = 1'b1;
    i_base        = base;
    i_count       = cnt;
    start_cyc     = cyc;
    run_reqs      = 0;
    run_push      = 0;
    first_req_cyc = -1;
    busy_cnt      = 0;
    tick();
    i_start = 1'b0;
    @(negedge clk);
    check("busy_after_start", 64'(o_busy), 64'd1);
    check("err_clear_after_start", 64'(o_err), 64'd0);
  endtask

  task automatic wait_reqs(input int n, input int budget);
    int k;
    k = 0;
    while ((run_reqs < n) && (k < budget)) begin
      tick();
      k++;
    end
    if (run_reqs < n) fail_now("wait_reqs_timeout");
  endtask

  task automatic wait_done(input int d0, input int budget);
    int k;
    k = 0;
    while ((done_cnt == d0) && (k < budget)) begin
      tick();
      k++;
    end
    if (done_cnt == d0) fail_now("wait_done_timeout");
  endtask

  initial begin
    int d0;
    int stall_left;
    bit stalled;

    i_reset        = 1'b1;
    i_start        = 1'b0;
    i_base         = '0;
    i_count        = '0;
    mc_rd_rq_stall = 1'b0;
    mc_rsp_push    = 1'b0;
    mc_rsp_data    = '0;
    mc_rsp_rdctl   = '0;
    for (int i = 0; i < 8; i++) mem[i] = '0;

    // Reset values
    tick();
    tick();
    @(negedge clk);
    check("rst_req_ld", 64'(mc_req_ld), 64'd0);
    check("rst_vadr", 64'(mc_req_vadr), 64'd0);
    check("rst_rdctl", mc_req_wrd_rdctl, 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_sum", o_sum, 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    check("req_size", 64'(mc_req_size), 64'd3);
    check("req_st_flush_stall", 64'({mc_req_st, mc_req_flush, mc_rsp_stall}), 64'd0);
`ifdef CAE_LDSUM_PERF_EN
    check("rst_cycles", 64'(o_cycles), 64'd0);
`endif
    tick();
    i_reset = 1'b0;

    // Basic in-order sum
    for (int i = 0; i < 4; i++) mem[i] = 64'(i + 1);
    auto_en = 1'b1;
    lat     = 1;
    expect_reqs(48'h1000, 4);
    expect_done(64'd10, 1'b0);
    d0 = done_cnt;
    start_run(48'h1000, 32'd4);
    wait_done(d0, 100);
    check("basic_first_req_latency", 64'(first_req_cyc - start_cyc), 64'd2);
    check("basic_done_latency", 64'(done_cyc - last_push_cyc), 64'd2);

    // Flow control: responses held back, then a 5-cycle stall mid-stream
    for (int i = 0; i < 6; i++) mem[i] = 64'(10 + i);
    expect_reqs(48'h8000, 6);
    expect_done(64'd75, 1'b0);
    hold_until = cyc + 12;
    d0         = done_cnt;
    start_run(48'h8000, 32'd6);
    stall_left = 0;
    stalled    = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (cyc == hold_until - 1) check("flow_hold_reqs", 64'(run_reqs), 64'd2);
      if (!stalled && (run_reqs >= 3)) begin
        stalled    = 1'b1;
        stall_left = 5;
      end
      mc_rd_rq_stall = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      if (done_cnt != d0) break;
    end
    mc_rd_rq_stall = 1'b0;
    if (done_cnt == d0) fail_now("flow_done_timeout");
    hold_until = 0;

    // Out-of-order returns with 64-bit wrap; base low bits ignored
    auto_en = 1'b0;
    expect_reqs(48'h2000, 3);
    expect_done(64'd1, 1'b0);
    d0 = done_cnt;
    start_run(48'h2005, 32'd3);
    wait_reqs(2, 20);
    tick();
    drive_rsp(32'd1, 64'd0);
    wait_reqs(3, 20);
    tick();
    drive_rsp(32'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    drive_rsp(32'd0, 64'd2);
    wait_done(d0, 20);
    check("ooo_done_latency", 64'(done_cyc - last_push_cyc), 64'd2);

    // Out-of-range rdctl sets the sticky error, data still summed
    expect_reqs(48'h3000, 3);
    expect_done(64'd16, 1'b1);
    d0 = done_cnt;
    start_run(48'h3000, 32'd3);
    wait_reqs(2, 20);
    tick();
    drive_rsp(32'd0, 64'd1);
    wait_reqs(3, 20);
    tick();
    drive_rsp(32'd7, 64'd5);
    tick();
    drive_rsp(32'd1, 64'd10);
    @(negedge clk);
    check("err_set_midrun", 64'(o_err), 64'd1);
    wait_done(d0, 20);

    // Start while busy is ignored but flagged
    mem[0]  = 64'd7;
    mem[1]  = 64'd8;
    auto_en = 1'b1;
    lat     = 2;
    expect_reqs(48'h4000, 2);
    expect_done(64'd15, 1'b1);
    d0 = done_cnt;
    start_run(48'h4000, 32'd2);
    tick();
    i_start = 1'b1;
    i_base  = 48'h9000;
    i_count = 32'd9;
    tick();
    i_start = 1'b0;
    wait_done(d0, 50);
    tick();
    @(negedge clk);
    check("err_held_idle", 64'(o_err), 64'd1);
    check("sum_held_idle", o_sum, 64'd15);

    // count = 0: done at T+2, no requests
    expect_done(64'd0, 1'b0);
    d0 = done_cnt;
    start_run(48'h7000, 32'd0);
    wait_done(d0, 10);
    check("zero_done_latency", 64'(done_cyc - start_cyc), 64'd2);
    check("zero_no_reqs", 64'(run_reqs), 64'd0);

    // Reset mid-run, stale responses afterwards are dropped
    auto_en = 1'b0;
    expect_reqs(48'h5000, 3);
    start_run(48'h5000, 32'd5);
    wait_reqs(2, 20);
    tick();
    drive_rsp(32'd0, 64'h99);
    wait_reqs(3, 20);
    tick();
    @(negedge clk);
    check("pre_reset_sum", o_sum, 64'h99);
    tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    @(negedge clk);
    check("midrst_req_ld", 64'(mc_req_ld), 64'd0);
    check("midrst_vadr", 64'(mc_req_vadr), 64'd0);
    check("midrst_rdctl", mc_req_wrd_rdctl, 64'd0);
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_sum", o_sum, 64'd0);
    check("midrst_err", 64'(o_err), 64'd0);
    d0 = done_cnt;
    tick();
    drive_rsp(32'd1, 64'h66);
    tick();
    drive_rsp(32'd7, 64'h77);
    tick();
    tick();
    @(negedge clk);
    check("stale_sum", o_sum, 64'd0);
    check("stale_err", 64'(o_err), 64'd0);
    check("stale_busy", 64'(o_busy), 64'd0);
    check("stale_no_done", 64'(done_cnt), 64'(d0));
    mem[0]  = 64'd5;
    auto_en = 1'b1;
    lat     = 1;
    expect_reqs(48'h6000, 1);
    expect_done(64'd5, 1'b0);
    start_run(48'h6000, 32'd1);
    wait_done(d0, 30);

`ifdef CAE_LDSUM_PERF_EN
    // Busy-cycle counter against a bench-side count
    for (int i = 0; i < 4; i++) mem[i] = 64'(i + 1);
    lat = 3;
    expect_reqs(48'h0, 4);
    expect_done(64'd10, 1'b0);
    d0 = done_cnt;
    start_run(48'h0, 32'd4);
    wait_done(d0, 100);
    check("perf_cycles", 64'(o_cycles), 64'(busy_cnt));
`endif

    auto_en = 1'b0;
    tick();
    tick();
    check("req_queue_drained", 64'(exp_vadr_q.size()), 64'd0);
    check("done_queue_drained", 64'(exp_sum_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
